exc_ctrl: RTL and testbench

- Exception/ERET sequencer directly upstream of the CP0 block.
- Collects exception requests from the ID and EX pipeline stages, masks them with CP0 status, and picks the oldest.
- Issues a one-cycle exception (or eret) pulse with cause and EPC to CP0, and drives pipeline flush and PC-redirect.
- Blocks further requests until the wrong-path instructions have drained.

---
 rtl/exc_pkg.sv | 22 ++
 rtl/exc_ctrl_if.sv | 41 ++++
 rtl/exc_prio.sv | 43 ++++
 rtl/exc_ctrl.sv | 109 ++++++++++
 tb/tb_exc_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared cause codes, status mask bits and FSM encoding for the exception sequencer
package exc_pkg;

  localparam logic [4:0] CAUSE_SYS = 5'd8;
  localparam logic [4:0] CAUSE_BP  = 5'd9;
  localparam logic [4:0] CAUSE_RI  = 5'd10;
  localparam logic [4:0] CAUSE_OV  = 5'd12;
  localparam logic [4:0] CAUSE_TR  = 5'd13;

  localparam int ST_SYS_BIT = 0;
  localparam int ST_BP_BIT  = 1;
  localparam int ST_TR_BIT  = 2;
  localparam int ST_OV_BIT  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXC   = 2'd1,
    S_FLUSH = 2'd2,
    S_RET   = 2'd3
  } exc_state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - pipeline request and CP0/flush response bundle for the exception sequencer
interface exc_ctrl_if;

  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_syscall;
  logic        id_break;
  logic        id_ri;
  logic        id_eret;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_ov;
  logic        ex_teq;
  logic [31:0] status;

  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic        pc_redirect;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        busy;

  modport master (
    output stall, id_valid, id_pc, id_syscall, id_break, id_ri, id_eret,
    output ex_valid, ex_pc, ex_ov, ex_teq, status,
    input  exception, eret, cause, epc, pc_redirect,
    input  flush_if, flush_id, flush_ex, busy
  );

  modport slave (
    input  stall, id_valid, id_pc, id_syscall, id_break, id_ri, id_eret,
    input  ex_valid, ex_pc, ex_ov, ex_teq, status,
    output exception, eret, cause, epc, pc_redirect,
    output flush_if, flush_id, flush_ex, busy
  );

endinterface

// File: rtl/exc_prio.sv
// rtl/exc_prio.sv - combinational masking and oldest-first priority pick of exception requests
module exc_prio
  import exc_pkg::*;
(
  input  logic       id_valid,
  input  logic       id_syscall,
  input  logic       id_break,
  input  logic       id_ri,
  input  logic       ex_valid,
  input  logic       ex_ov,
  input  logic       ex_teq,
  input  logic [3:0] status_mask,
  output logic       req,
  output logic [4:0] cause,
  output logic       sel_ex
);

  // EX holds the older instruction, so its requests are checked first
  always_comb begin
    req    = 1'b0;
    cause  = 5'd0;
    sel_ex = 1'b0;
    if (ex_valid && ex_ov && status_mask[ST_OV_BIT]) begin
      req    = 1'b1;
      cause  = CAUSE_OV;
      sel_ex = 1'b1;
    end else if (ex_valid && ex_teq && status_mask[ST_TR_BIT]) begin
      req    = 1'b1;
      cause  = CAUSE_TR;
      sel_ex = 1'b1;
    end else if (id_valid && id_ri) begin
      req   = 1'b1;
      cause = CAUSE_RI;
    end else if (id_valid && id_syscall && status_mask[ST_SYS_BIT]) begin
      req   = 1'b1;
      cause = CAUSE_SYS;
    end else if (id_valid && id_break && status_mask[ST_BP_BIT]) begin
      req   = 1'b1;
      cause = CAUSE_BP;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/eret sequencer: CP0 pulses, PC redirect and wrong-path flush
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h00400000
) (
  input  logic      clk,
  input  logic      rst,
  exc_ctrl_if.slave bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_ex_q, sel_ex_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        prio_req;
  logic [4:0]  prio_cause;
  logic        prio_sel_ex;
  logic        unused_status;

  assign unused_status = ^bus.status[31:4];

  exc_prio u_prio (
    .id_valid    (bus.id_valid),
    .id_syscall  (bus.id_syscall),
    .id_break    (bus.id_break),
    .id_ri       (bus.id_ri),
    .ex_valid    (bus.ex_valid),
    .ex_ov       (bus.ex_ov),
    .ex_teq      (bus.ex_teq),
    .status_mask (bus.status[3:0]),
    .req         (prio_req),
    .cause       (prio_cause),
    .sel_ex      (prio_sel_ex)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      sel_ex_q <= 1'b0;
      cause_q  <= 5'd0;
      epc_q    <= RESET_PC;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_ex_q <= sel_ex_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_ex_d = sel_ex_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.stall) begin
          if (prio_req) begin
            state_d  = S_EXC;
            cause_d  = prio_cause;
            epc_d    = prio_sel_ex ? bus.ex_pc : bus.id_pc;
            sel_ex_d = prio_sel_ex;
          end else if (bus.id_valid && bus.id_eret) begin
            state_d = S_RET;
          end
        end
      end
      S_EXC: begin
        cnt_d   = FLUSH_LOAD;
        state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end
      end
      S_RET: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // An ID-stage winner leaves the older EX instruction alive to complete
  always_comb begin
    bus.exception   = (state_q == S_EXC);
    bus.eret        = (state_q == S_RET);
    bus.pc_redirect = (state_q == S_EXC) || (state_q == S_RET);
    bus.flush_if    = (state_q != S_IDLE);
    bus.flush_id    = (state_q != S_IDLE);
    bus.flush_ex    = sel_ex_q && ((state_q == S_EXC) || (state_q == S_FLUSH));
    bus.busy        = (state_q != S_IDLE);
    bus.cause       = cause_q;
    bus.epc         = epc_q;
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - self-checking bench for exc_ctrl with a schedule-based reference model
module tb_exc_ctrl;
  import exc_pkg::*;

  localparam int unsigned FC  = 2;
  localparam logic [31:0] RPC = 32'h00400000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  exc_ctrl_if bus ();

  exc_ctrl #(.FLUSH_CYCLES(FC), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic exc, eret, redir, fif, fid, fex, busy;
  } ctl_t;

  ctl_t        sched[$];
  ctl_t        cur     = '0;
  ctl_t        ent;
  logic [4:0]  m_cause = 5'd0;
  logic [31:0] m_epc   = RPC;
  logic        w_hit, w_ex;
  logic [4:0]  w_code;

  function automatic void winner(output logic hit, output logic [4:0] code, output logic from_ex);
    hit = 1'b1; from_ex = 1'b1; code = 5'd0;
    if      (bus.ex_valid && bus.ex_ov  && bus.status[3]) code = 5'd12;
    else if (bus.ex_valid && bus.ex_teq && bus.status[2]) code = 5'd13;
    else begin
      from_ex = 1'b0;
      if      (bus.id_valid && bus.id_ri)                      code = 5'd10;
      else if (bus.id_valid && bus.id_syscall && bus.status[0]) code = 5'd8;
      else if (bus.id_valid && bus.id_break   && bus.status[1]) code = 5'd9;
      else hit = 1'b0;
    end
  endfunction

  // Each accepted event expands into the list of per-cycle outputs it must produce
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched.delete();
      cur     = '0;
      m_cause = 5'd0;
      m_epc   = RPC;
    end else begin
      if (!cur.busy && !bus.stall) begin
        winner(w_hit, w_code, w_ex);
        if (w_hit) begin
          m_cause = w_code;
          m_epc   = w_ex ? bus.ex_pc : bus.id_pc;
          for (int k = 0; k < int'(FC); k++) begin
            ent = '0;
            ent.exc = (k == 0); ent.redir = (k == 0);
            ent.fif = 1'b1; ent.fid = 1'b1; ent.fex = w_ex; ent.busy = 1'b1;
            sched.push_back(ent);
          end
        end else if (bus.id_valid && bus.id_eret) begin
          ent = '0;
          ent.eret = 1'b1; ent.redir = 1'b1; ent.fif = 1'b1; ent.fid = 1'b1; ent.busy = 1'b1;
          sched.push_back(ent);
        end
      end
      cur = (sched.size() != 0) ? sched.pop_front() : ctl_t'('0);
    end
  end

  logic [43:0] got_v, exp_v;
  always @(negedge clk) begin
    got_v = {bus.exception, bus.eret, bus.pc_redirect, bus.flush_if, bus.flush_id,
             bus.flush_ex, bus.busy, bus.cause, bus.epc};
    exp_v = {cur, m_cause, m_epc};
    n_assert++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.stall = 0; bus.id_valid = 0; bus.id_pc = 0; bus.id_syscall = 0; bus.id_break = 0;
    bus.id_ri = 0; bus.id_eret = 0; bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_ov = 0; bus.ex_teq = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_req(input logic [31:0] pc, input logic sys, input logic brk, input logic ri, input logic er);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_syscall = sys; bus.id_break = brk;
    bus.id_ri = ri; bus.id_eret = er;
  endtask

  task automatic ex_req(input logic [31:0] pc, input logic ov, input logic teq);
    bus.ex_valid = 1; bus.ex_pc = pc; bus.ex_ov = ov; bus.ex_teq = teq;
  endtask

  initial begin
    clr();
    bus.status = 32'h0;
    step(); step();
    chk("rst_exception", {31'd0, bus.exception}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst_epc",       bus.epc, RPC);
    chk("rst_cause",     {27'd0, bus.cause}, 32'd0);
    rst = 1; step();

    // syscall from ID
    bus.status = 32'hF;
    id_req(32'h00400010, 1, 0, 0, 0);
    step(); clr();
    chk("t1_exception", {31'd0, bus.exception}, 32'd1);
    chk("t1_cause",     {27'd0, bus.cause}, 32'd8);
    chk("t1_epc",       bus.epc, 32'h00400010);
    chk("t1_flush",     {29'd0, bus.flush_if, bus.flush_id, bus.flush_ex}, 32'b110);
    step();
    chk("t1_pulse_len", {30'd0, bus.exception, bus.busy}, 32'b01);
    step();
    chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);

    // EX overflow beats a simultaneous ID break
    ex_req(32'h0040000C, 1, 0);
    id_req(32'h00400020, 0, 1, 0, 0);
    step(); clr();
    chk("t2_cause",    {27'd0, bus.cause}, 32'd12);
    chk("t2_epc",      bus.epc, 32'h0040000C);
    chk("t2_flush_ex", {31'd0, bus.flush_ex}, 32'd1);
    step(); step();

    // masked syscall ignored, RI never masked
    bus.status = 32'hE;
    id_req(32'h00400030, 1, 0, 0, 0);
    step(); clr();
    chk("t3_masked", {30'd0, bus.exception, bus.busy}, 32'd0);
    step();
    bus.status = 32'h0;
    id_req(32'h00400040, 0, 0, 1, 0);
    step(); clr();
    chk("t3_ri_cause", {27'd0, bus.cause}, 32'd10);
    chk("t3_ri_epc",   bus.epc, 32'h00400040);
    step(); step();

    // eret
    id_req(32'h00400050, 0, 0, 0, 1);
    step(); clr();
    chk("t4_eret",  {26'd0, bus.eret, bus.pc_redirect, bus.flush_if, bus.flush_id, bus.flush_ex, bus.exception}, 32'b111100);
    chk("t4_hold",  bus.epc, 32'h00400040);
    step();
    chk("t4_done",  {30'd0, bus.eret, bus.busy}, 32'd0);

    // requests during EXC/FLUSH and under stall are ignored
    bus.status = 32'hF;
    id_req(32'h00400060, 1, 0, 0, 0);
    step(); clr();
    ex_req(32'h00400070, 0, 1);
    step();
    chk("t5_no_repulse", {31'd0, bus.exception}, 32'd0);
    step(); clr();
    chk("t5_idle", {27'd0, bus.busy, bus.cause[3:0]}, 32'h8);
    bus.stall = 1;
    id_req(32'h00400078, 1, 0, 0, 1);
    ex_req(32'h0040007C, 1, 0);
    step(); step(); clr();
    chk("t5_stall", {29'd0, bus.exception, bus.eret, bus.busy}, 32'd0);
    step();

    // trap beats eret; break alone
    ex_req(32'h00400080, 0, 1);
    id_req(32'h00400084, 0, 0, 0, 1);
    step(); clr();
    chk("t5_teq_cause", {27'd0, bus.cause}, 32'd13);
    chk("t5_teq_noeret", {31'd0, bus.eret}, 32'd0);
    step(); step();
    id_req(32'h00400090, 0, 1, 0, 0);
    step(); clr();
    chk("t5_bp_cause", {27'd0, bus.cause}, 32'd9);
    step(); step();

    // reset during FLUSH
    id_req(32'h004000A0, 1, 0, 0, 0);
    step(); clr();
    step();
    rst = 0; #1;
    chk("t6_rst_outs", {25'd0, bus.exception, bus.eret, bus.pc_redirect, bus.flush_if, bus.flush_id, bus.flush_ex, bus.busy}, 32'd0);
    chk("t6_rst_epc",  bus.epc, RPC);
    step(); rst = 1; step();
    id_req(32'h004000B0, 1, 0, 0, 0);
    step(); clr();
    chk("t6_after_exc", {31'd0, bus.exception}, 32'd1);
    chk("t6_after_epc", bus.epc, 32'h004000B0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
